// File: rtl/sha_pkg.sv
// -----------------------------------------------------------------------------
// sha_pkg
// Shared SHA-256 types and constants for the hash core and its controllers.
//   word_t   : one 32-bit SHA word
//   hash_t   : 8-word nonce/hash, index 0 is the most significant word
//   H_INIT   : SHA-256 initial hash value
//   K_TBL    : SHA-256 round constants
//   state_t  : nonce_search_ctrl FSM states
// -----------------------------------------------------------------------------
package sha_pkg;

   typedef logic [31:0] word_t;
   // [0:7] so that element 0 lands in the top bits of the flat 256-bit bus.
   typedef word_t [0:7] hash_t;

   localparam hash_t H_INIT = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   localparam word_t K_TBL [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_CHECK,
      ST_DONE
   } state_t;

endpackage

// File: rtl/hash_less_than.sv
// -----------------------------------------------------------------------------
// hash_less_than
// Combinational 256-bit unsigned strict compare, o_lt = (i_a < i_b).
// Words are scanned from word 0 (most significant); the first differing word
// decides, equal values give 0.
//   i_a, i_b : 256-bit operands, word 0 in bits [255:224]
//   o_lt     : 1 when i_a is strictly below i_b
// -----------------------------------------------------------------------------
module hash_less_than
   import sha_pkg::*;
(
   input  logic [255:0] i_a,
   input  logic [255:0] i_b,
   output logic         o_lt
);

   hash_t w_a;
   hash_t w_b;
   logic  w_lt;
   logic  w_dec;

   assign w_a = i_a;
   assign w_b = i_b;

   always_comb begin
      w_lt  = 1'b0;
      w_dec = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (!w_dec && (w_a[i] != w_b[i])) begin
            w_lt  = (w_a[i] < w_b[i]);
            w_dec = 1'b1;
         end
      end
   end

   assign o_lt = w_lt;

endmodule

// File: rtl/nonce_search_ctrl.sv
// -----------------------------------------------------------------------------
// nonce_search_ctrl
// Feeds candidate nonces to one SHA-256 hash core and watches the returned
// hash. Stops on the first hash strictly below the target, after maxIter
// candidates, or on abort.
//   i_clk, i_rst     : clock, synchronous active-high reset
//   i_start          : begin a search (IDLE only; wins over i_abort)
//   i_abort          : end a running search, result discarded
//   i_seed           : first nonce (word 0 in bits [255:224])
//   i_target         : hash threshold, same layout
//   i_maxIter        : number of candidates to try
//   o_busy           : high outside IDLE
//   o_done           : one-cycle pulse when a search ends
//   o_found          : a hit was found (held until next start)
//   o_foundNonce     : winning nonce (held)
//   o_foundHash      : winning hash (held)
//   o_iterCount      : candidates checked (held)
//   o_hNonce         : nonce presented to the hash core
//   i_hHash          : hash returned by the hash core
// -----------------------------------------------------------------------------
module nonce_search_ctrl
   import sha_pkg::*;
#(
   parameter int HASH_LATENCY = 0,
   parameter int CNT_W        = 32
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_start,
   input  logic               i_abort,
   input  logic [255:0]       i_seed,
   input  logic [255:0]       i_target,
   input  logic [CNT_W-1:0]   i_maxIter,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_found,
   output logic [255:0]       o_foundNonce,
   output logic [255:0]       o_foundHash,
   output logic [CNT_W-1:0]   o_iterCount,
   output logic [255:0]       o_hNonce,
   input  logic [255:0]       i_hHash
);

   localparam int LAT_W = (HASH_LATENCY > 1) ? $clog2(HASH_LATENCY) : 1;
   localparam logic [LAT_W-1:0] LAT_LAST =
      LAT_W'((HASH_LATENCY > 0) ? HASH_LATENCY - 1 : 0);

   state_t             r_state;
   logic               r_busy;
   logic               r_done;
   logic               r_found;
   hash_t              r_nonce;
   logic [255:0]       r_fnonce;
   logic [255:0]       r_fhash;
   logic [CNT_W-1:0]   r_iter;
   logic [CNT_W-1:0]   r_max;
   logic [255:0]       r_target;
   logic [LAT_W-1:0]   r_lat;

   logic               w_lt;
   logic [CNT_W-1:0]   w_iter_nxt;

   hash_less_than u_cmp (
      .i_a  (i_hHash),
      .i_b  (r_target),
      .o_lt (w_lt)
   );

   assign w_iter_nxt = r_iter + 1'b1;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= ST_IDLE;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_found  <= 1'b0;
         r_nonce  <= '0;
         r_fnonce <= '0;
         r_fhash  <= '0;
         r_iter   <= '0;
         r_max    <= '0;
         r_target <= '0;
         r_lat    <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_target <= i_target;
                  r_max    <= i_maxIter;
                  r_nonce  <= i_seed;
                  r_iter   <= '0;
                  r_found  <= 1'b0;
                  r_busy   <= 1'b1;
                  if (i_maxIter == '0) begin
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= ST_ISSUE;
                  end
               end
            end
            ST_ISSUE: begin
               if (i_abort) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
               end else if (HASH_LATENCY > 0) begin
                  r_lat   <= '0;
                  r_state <= ST_WAIT;
               end else begin
                  r_state <= ST_CHECK;
               end
            end
            ST_WAIT: begin
               if (i_abort) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
               end else if (r_lat == LAT_LAST) begin
                  r_state <= ST_CHECK;
               end else begin
                  r_lat <= r_lat + 1'b1;
               end
            end
            ST_CHECK: begin
               // An abort here drops this candidate entirely: no count, no hit.
               if (i_abort) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
               end else begin
                  r_iter <= w_iter_nxt;
                  if (w_lt) begin
                     r_found  <= 1'b1;
                     r_fnonce <= r_nonce;
                     r_fhash  <= i_hHash;
                     r_state  <= ST_DONE;
                     r_done   <= 1'b1;
                  end else if (w_iter_nxt == r_max) begin
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     // Only the last word steps; it wraps without carrying.
                     r_nonce[7] <= r_nonce[7] + 32'd1;
                     r_state    <= ST_ISSUE;
                  end
               end
            end
            ST_DONE: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_busy       = r_busy;
   assign o_done       = r_done;
   assign o_found      = r_found;
   assign o_foundNonce = r_fnonce;
   assign o_foundHash  = r_fhash;
   assign o_iterCount  = r_iter;
   assign o_hNonce     = r_nonce;

endmodule

// File: tb/tb_nonce_search_ctrl.sv
// -----------------------------------------------------------------------------
// tb_nonce_search_ctrl
// Three controllers (hash latency 0, 2, 3) each driven by a behavioural hash
// core. Expected results come from a candidate-by-candidate search model.
// -----------------------------------------------------------------------------
module tb_nonce_search_ctrl;

   localparam int NDUT = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic [255:0]  seed, target;
   logic [31:0]   maxIter;
   logic          start   [NDUT];
   logic          abort   [NDUT];
   logic          busy    [NDUT];
   logic          done    [NDUT];
   logic          found   [NDUT];
   logic [255:0]  fnonce  [NDUT];
   logic [255:0]  fhash   [NDUT];
   logic [31:0]   iter    [NDUT];
   logic [255:0]  hnonce  [NDUT];
   logic [255:0]  hhash   [NDUT];

   // hash-core model controls
   int            hmode;
   logic [255:0]  htgt;
   logic [31:0]   hbase;

   // held results expected on each DUT
   logic [255:0]  m_fn [NDUT];
   logic [255:0]  m_fh [NDUT];

   int errs   = 0;
   int checks = 0;

   always #5 clk = ~clk;

   function automatic int lat_of(input int d);
      return (d == 0) ? 0 : ((d == 1) ? 2 : 3);
   endfunction

   // mode 0: cheap mixing hash; mode 1: scripted hits keyed on candidate index
   function automatic logic [255:0] hfun(input logic [255:0] x, input int mode,
                                         input logic [255:0] tgt, input logic [31:0] base);
      logic [31:0] k;
      if (mode == 1) begin
         k = x[31:0] - base;
         if (k == 32'd0) return tgt;
         if (k == 32'd2) return tgt - 256'd1;
         return '1;
      end
      return {(x[31:0] * 32'h9E3779B1) ^ x[255:224], x[223:0]};
   endfunction

   function automatic logic [255:0] rnd256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      localparam int L = (g == 0) ? 0 : ((g == 1) ? 2 : 3);
      logic [255:0] dl [0:3];
      logic [255:0] w_src;
      always @(posedge clk) begin
         dl[0] <= hnonce[g];
         for (int j = 1; j < 4; j++) dl[j] <= dl[j-1];
      end
      if (L == 0) begin : g_comb
         assign w_src = hnonce[g];
      end else begin : g_dly
         assign w_src = dl[L-1];
      end
      assign hhash[g] = hfun(w_src, hmode, htgt, hbase);

      nonce_search_ctrl #(.HASH_LATENCY(L), .CNT_W(32)) u_dut (
         .i_clk        (clk),
         .i_rst        (rst),
         .i_start      (start[g]),
         .i_abort      (abort[g]),
         .i_seed       (seed),
         .i_target     (target),
         .i_maxIter    (maxIter),
         .o_busy       (busy[g]),
         .o_done       (done[g]),
         .o_found      (found[g]),
         .o_foundNonce (fnonce[g]),
         .o_foundHash  (fhash[g]),
         .o_iterCount  (iter[g]),
         .o_hNonce     (hnonce[g]),
         .i_hHash      (hhash[g])
      );
   end

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input int d);
      chk("rst_busy",   256'(busy[d]),  256'(0));
      chk("rst_done",   256'(done[d]),  256'(0));
      chk("rst_found",  256'(found[d]), 256'(0));
      chk("rst_fnonce", fnonce[d],      256'(0));
      chk("rst_fhash",  fhash[d],       256'(0));
      chk("rst_iter",   256'(iter[d]),  256'(0));
      chk("rst_hnonce", hnonce[d],      256'(0));
   endtask

   // abort_cyc: -1 = abort together with start, 0 = none, >0 = cycle to abort in
   // busy_start_cyc: cycle in which a stray start is pulsed (0 = none)
   task automatic run(input int d, input logic [255:0] s, input logic [255:0] t,
                      input logic [31:0] n, input int abort_cyc, input int busy_start_cyc);
      int           L, exp_done, cyc, k, cnt;
      logic         exp_found;
      logic [31:0]  exp_iter;
      logic [255:0] nz, h, hit_n, hit_h;
      L = lat_of(d);

      // reference: walk candidates in order, stop at first hash below target
      exp_found = 1'b0;
      exp_iter  = n;
      exp_done  = 1 + int'(n) * (L + 2);
      hit_n = '0; hit_h = '0;
      for (int j = 0; j < int'(n); j++) begin
         nz = {s[255:32], s[31:0] + 32'(j)};
         h  = hfun(nz, hmode, htgt, hbase);
         if (h < t) begin
            exp_found = 1'b1;
            exp_iter  = 32'(j + 1);
            exp_done  = 1 + (j + 1) * (L + 2);
            hit_n = nz; hit_h = h;
            break;
         end
      end
      if (abort_cyc > 0 && abort_cyc < exp_done) begin
         cnt = 0;
         for (int j = 0; j < int'(n); j++) if ((j + 1) * (L + 2) < abort_cyc) cnt++;
         exp_found = 1'b0;
         exp_iter  = 32'(cnt);
         exp_done  = abort_cyc + 1;
      end
      if (exp_found) begin
         m_fn[d] = hit_n;
         m_fh[d] = hit_h;
      end

      @(negedge clk);
      seed = s; target = t; maxIter = n; start[d] = 1'b1;
      if (abort_cyc == -1) abort[d] = 1'b1;
      @(negedge clk);
      // later changes to the inputs must not leak into the running search
      seed = ~s; target = ~t; maxIter = n + 32'd3;
      for (cyc = 1; cyc <= 300; cyc++) begin
         start[d] = 1'b0;
         abort[d] = 1'b0;
         if (cyc == 1) chk("busy_c1", 256'(busy[d]), 256'(1));
         if (cyc < exp_done && ((cyc - 1) % (L + 2)) == 0) begin
            k = (cyc - 1) / (L + 2);
            chk("hnonce", hnonce[d], {s[255:32], s[31:0] + 32'(k)});
         end
         if (done[d]) break;
         if (cyc == abort_cyc) abort[d] = 1'b1;
         if (cyc == busy_start_cyc) begin
            start[d] = 1'b1;
            seed     = rnd256();
            maxIter  = 32'd1;
         end
         @(negedge clk);
      end
      start[d] = 1'b0;
      abort[d] = 1'b0;
      chk("done_cycle", 256'(cyc), 256'(exp_done));
      chk("found",  256'(found[d]), 256'(exp_found));
      chk("iter",   256'(iter[d]),  256'(exp_iter));
      chk("fnonce", fnonce[d], m_fn[d]);
      chk("fhash",  fhash[d],  m_fh[d]);
      @(negedge clk);
      chk("done_pulse", 256'(done[d]), 256'(0));
      chk("idle_busy",  256'(busy[d]), 256'(0));
   endtask

   initial begin
      logic [255:0] s, t;
      int           ab;

      rst = 1'b1; seed = '0; target = '0; maxIter = '0;
      hmode = 0; htgt = '0; hbase = '0;
      for (int d = 0; d < NDUT; d++) begin
         start[d] = 1'b0; abort[d] = 1'b0; m_fn[d] = '0; m_fh[d] = '0;
      end
      repeat (3) @(negedge clk);
      for (int d = 0; d < NDUT; d++) chk_reset(d);
      rst = 1'b0;

      // zero nonce hits an all-ones target immediately; abort with start is ignored
      run(0, '0, '1, 32'd5, -1, 0);
      // target 0 never hits: five candidates, word7 0..4
      run(0, '0, '0, 32'd5, 0, 0);
      // word7 wraps without touching word6
      run(0, {{7{32'h11111111}}, 32'hFFFFFFFE}, '0, 32'd3, 0, 0);
      // maxIter 0 finishes straight away
      run(1, rnd256(), '1, 32'd0, 0, 0);

      // scripted core: equal on candidate 0, target-1 on candidate 2, latency 3
      hmode = 1; hbase = 32'h00000100;
      htgt  = {32'h00001000, 224'h0};
      s = rnd256(); s[31:0] = hbase;
      run(2, s, htgt, 32'd8, 0, 0);
      hmode = 0;

      // abort in WAIT of candidate 1 at latency 2, stray start while busy
      run(1, rnd256(), '0, 32'd5, 6, 3);

      // reset during CHECK of candidate 1
      @(negedge clk);
      seed = '0; target = '0; maxIter = 32'd5; start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int d = 0; d < NDUT; d++) begin
         chk_reset(d);
         m_fn[d] = '0; m_fh[d] = '0;
      end
      repeat (3) begin
         @(negedge clk);
         chk("post_rst_done", 256'(done[0]), 256'(0));
      end
      run(0, '0, '1, 32'd5, 0, 0);

      // random searches
      for (int r = 0; r < 24; r++) begin
         s = rnd256();
         t = rnd256();
         t[255:224] = $urandom_range(0, 32'h0FFFFFFF);
         ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 24)) : 0;
         run(int'($urandom_range(0, NDUT - 1)), s, t, 32'($urandom_range(0, 8)), ab, 0);
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/nonce_search_ctrl.md
Name: nonce_search_ctrl

Overview:
- Sequential producer/consumer at the far end of the hash core's nonce->hash interface.
- Drives 8-word candidate nonces into the SHA-256 hash core and samples the 8-word hash it returns.
- Compares each hash against a 256-bit target and reports the first nonce whose hash is strictly below target, or reports exhaustion after a programmable iteration count.
- Sits between the host/control logic and one hash core instance.

Parameters:
HASH_LATENCY, 0, cycles from hNonce change to hHash valid (0 = combinational hash core)
CNT_W, 32, width of iteration limit and iteration counter

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
start  input  1  begin search; sampled only in IDLE
abort  input  1  terminate search; sampled in ISSUE/WAIT/CHECK
seed  input  256  initial nonce; word i at bits [32i:32i+31], [0:255] numbering, word 0 most significant
target  input  256  threshold, same word layout
maxIter  input  CNT_W  number of candidates to try
busy  output  1  high in any state except IDLE
done  output  1  one-cycle pulse when search ends
found  output  1  result flag, held until next accepted start
foundNonce  output  256  winning nonce, held
foundHash  output  256  winning hash, held
iterCount  output  CNT_W  candidates checked, held
hNonce  output  256  nonce to hash core, registered
hHash  input  256  hash from hash core

Behaviour:
- Reset: state=IDLE; busy=0, done=0, found=0, foundNonce=0, foundHash=0, iterCount=0, hNonce=0. rst mid-search aborts immediately, no done pulse.
- States: IDLE, ISSUE, WAIT, CHECK, DONE.
- IDLE: on start, latch seed/target/maxIter; hNonce<=seed; iterCount<=0; found<=0. If maxIter==0 -> DONE, else -> ISSUE.
- ISSUE, 1 cycle: hNonce stable. -> WAIT if HASH_LATENCY>0, else -> CHECK.
- WAIT: latency counter counts HASH_LATENCY cycles, then -> CHECK.
- CHECK, 1 cycle: iterCount<=iterCount+1.
  - If hHash < target (unsigned 256-bit, strict; equal is not found): found<=1; foundNonce<=hNonce; foundHash<=hHash; -> DONE.
  - Else if iterCount+1==maxIter -> DONE.
  - Else hNonce word 7 <=word7+1, mod 2^32, wrapping 0xFFFFFFFF->0x00000000 with no carry into word 6; -> ISSUE.
- DONE, 1 cycle: done=1; -> IDLE.
- Timing: candidate k (0-based) occupies HASH_LATENCY+2 cycles.
  - Start sampled at cycle 0.
  - Exhausted search of N candidates: done in cycle 1+N(L+2).
  - Hit on candidate k: done in cycle 1+(k+1)(L+2).
- abort in ISSUE/WAIT/CHECK: -> DONE next cycle; found=0; iterCount keeps completed count. CHECK results in that cycle are discarded.
- start while busy: ignored. start and abort in IDLE: start wins, abort ignored.
- Target latched at start; changes to seed/target/maxIter while busy have no effect.
- Words 0-6 of hNonce never change during a search.

Decomposition:
- Package sha_pkg:
  - 32-bit word type, 8-word hash/nonce type.
  - Initial hash constants and 64-entry K table, shared with the hash core.
  - State enum for this block.
- Sub-module hash_less_than: combinational 256-bit unsigned strict compare, word 0 first. Reused by future difficulty logic.

Test Plan:
- seed=0, target=all ones, maxIter=5, L=0 -> done at cycle 3, found=1, iterCount=1, foundNonce=0, foundHash=SHA-256 of the zero nonce.
- target=0, maxIter=5, L=0 -> done at cycle 11, found=0, iterCount=5, hNonce word7 sequence 0,1,2,3,4.
- seed word7=0xFFFFFFFE, other words 0x11111111, target=0, maxIter=3 -> word7 sequence 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000; word6 stays 0x11111111.
- Behavioural hash model returns hash==target on candidate 0 and target-1 on candidate 2, L=3 -> found=1, iterCount=3, foundNonce word7=seed+2, done at cycle 16.
- abort in WAIT of candidate 1, L=2 -> done next cycle, found=0, iterCount=1; start pulsed while busy is ignored.
- rst asserted in CHECK -> next cycle all outputs at reset values, no done pulse; fresh start then completes normally.
